// File: rtl/axi_lite_rr_arbiter.sv
// axi_lite_rr_arbiter: N-master to 1-slave AXI-lite arbiter.
// Read and write paths arbitrate independently with round-robin fairness.
// Each path allows one outstanding transaction.
// Optional response watchdog: define AXI_ARB_TIMEOUT_EN to enable.
// When it fires, the master gets DECERR and the late slave response is drained.
module axi_lite_rr_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_awaddr,
  input  logic [NUM_MASTERS*3-1:0]          m_awport,
  input  logic [NUM_MASTERS-1:0]            m_awvalid,
  output logic [NUM_MASTERS-1:0]            m_awready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_wstrb,
  input  logic [NUM_MASTERS-1:0]            m_wvalid,
  output logic [NUM_MASTERS-1:0]            m_wready,
  output logic [NUM_MASTERS-1:0]            m_bvalid,
  output logic [NUM_MASTERS*2-1:0]          m_bresp,
  input  logic [NUM_MASTERS-1:0]            m_bready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr,
  input  logic [NUM_MASTERS*3-1:0]          m_arport,
  input  logic [NUM_MASTERS-1:0]            m_arvalid,
  output logic [NUM_MASTERS-1:0]            m_arready,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  output logic [NUM_MASTERS*2-1:0]          m_rresp,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
  input  logic [NUM_MASTERS-1:0]            m_rready,
  output logic [ADDR_WIDTH-1:0]             s_awaddr,
  output logic [2:0]                        s_awport,
  output logic                              s_awvalid,
  input  logic                              s_awready,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  output logic [DATA_WIDTH/8-1:0]           s_wstrb,
  output logic                              s_wvalid,
  input  logic                              s_wready,
  input  logic                              s_bvalid,
  input  logic [1:0]                        s_bresp,
  output logic                              s_bready,
  output logic [ADDR_WIDTH-1:0]             s_araddr,
  output logic [2:0]                        s_arport,
  output logic                              s_arvalid,
  input  logic                              s_arready,
  input  logic                              s_rvalid,
  input  logic [1:0]                        s_rresp,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  output logic                              s_rready
);
  localparam int IDX_W  = $clog2(NUM_MASTERS);
  localparam int STRB_W = DATA_WIDTH / 8;

  // Reject unsupported configurations at elaboration time.
  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("axi_lite_rr_arbiter: unsupported parameter set");
  end

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_RESP, ST_ERR, ST_DRAIN} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_RESP} state_e;
`endif

  // First requester strictly after ptr, wrapping modulo NUM_MASTERS.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_MASTERS);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  state_e           w_state_q, w_state_d, r_state_q, r_state_d;
  logic [IDX_W-1:0] w_grant_q, w_grant_d, r_grant_q, r_grant_d;
  logic [IDX_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0] r_data;
`ifdef AXI_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
`endif

  // Write path: grant, AW/W forwarding with independent done flags, B routing.
  always_comb begin
    w_state_d = w_state_q;
    w_grant_d = w_grant_q;
    wptr_d    = wptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    s_awaddr  = '0;
    s_awport  = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bresp   = '0;
`ifdef AXI_ARB_TIMEOUT_EN
    w_cnt_d   = w_cnt_q;
`endif
    case (w_state_q)
      ST_IDLE: begin
        if (|m_awvalid) begin
          w_grant_d = rr_pick(m_awvalid, wptr_q);
          w_state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        s_awaddr  = m_awaddr[w_grant_q*ADDR_WIDTH +: ADDR_WIDTH];
        s_awport  = m_awport[w_grant_q*3 +: 3];
        s_wdata   = m_wdata[w_grant_q*DATA_WIDTH +: DATA_WIDTH];
        s_wstrb   = m_wstrb[w_grant_q*STRB_W +: STRB_W];
        s_awvalid = m_awvalid[w_grant_q] & ~aw_done_q;
        s_wvalid  = m_wvalid[w_grant_q] & ~w_done_q;
        m_awready[w_grant_q] = s_awready & ~aw_done_q;
        m_wready[w_grant_q]  = s_wready & ~w_done_q;
        if (s_awvalid && s_awready) aw_done_d = 1'b1;
        if (s_wvalid && s_wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          w_state_d = ST_RESP;
`ifdef AXI_ARB_TIMEOUT_EN
          w_cnt_d   = '0;
`endif
        end
      end
      ST_RESP: begin
        s_bready                    = m_bready[w_grant_q];
        m_bvalid[w_grant_q]         = s_bvalid;
        m_bresp[w_grant_q*2 +: 2]   = s_bresp;
        if (s_bvalid) begin
          if (m_bready[w_grant_q]) begin
            wptr_d    = w_grant_q;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            w_state_d = ST_IDLE;
          end
        end
`ifdef AXI_ARB_TIMEOUT_EN
        else if (w_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) w_state_d = ST_ERR;
        else w_cnt_d = w_cnt_q + 1'b1;
`endif
      end
`ifdef AXI_ARB_TIMEOUT_EN
      ST_ERR: begin
        m_bvalid[w_grant_q]       = 1'b1;
        m_bresp[w_grant_q*2 +: 2] = 2'b11;
        if (m_bready[w_grant_q]) w_state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        s_bready = 1'b1;
        if (s_bvalid) begin
          wptr_d    = w_grant_q;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = ST_IDLE;
        end
      end
`endif
      default: w_state_d = ST_IDLE;
    endcase
  end

  // Read path: grant, AR forwarding, R routing with broadcast data.
  always_comb begin
    r_state_d = r_state_q;
    r_grant_d = r_grant_q;
    rptr_d    = rptr_q;
    s_araddr  = '0;
    s_arport  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    m_rresp   = '0;
    r_data    = '0;
`ifdef AXI_ARB_TIMEOUT_EN
    r_cnt_d   = r_cnt_q;
`endif
    case (r_state_q)
      ST_IDLE: begin
        if (|m_arvalid) begin
          r_grant_d = rr_pick(m_arvalid, rptr_q);
          r_state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        s_araddr  = m_araddr[r_grant_q*ADDR_WIDTH +: ADDR_WIDTH];
        s_arport  = m_arport[r_grant_q*3 +: 3];
        s_arvalid = m_arvalid[r_grant_q];
        m_arready[r_grant_q] = s_arready;
        if (s_arvalid && s_arready) begin
          r_state_d = ST_RESP;
`ifdef AXI_ARB_TIMEOUT_EN
          r_cnt_d   = '0;
`endif
        end
      end
      ST_RESP: begin
        s_rready                  = m_rready[r_grant_q];
        m_rvalid[r_grant_q]       = s_rvalid;
        m_rresp[r_grant_q*2 +: 2] = s_rresp;
        r_data                    = s_rdata;
        if (s_rvalid) begin
          if (m_rready[r_grant_q]) begin
            rptr_d    = r_grant_q;
            r_state_d = ST_IDLE;
          end
        end
`ifdef AXI_ARB_TIMEOUT_EN
        else if (r_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) r_state_d = ST_ERR;
        else r_cnt_d = r_cnt_q + 1'b1;
`endif
      end
`ifdef AXI_ARB_TIMEOUT_EN
      ST_ERR: begin
        m_rvalid[r_grant_q]       = 1'b1;
        m_rresp[r_grant_q*2 +: 2] = 2'b11;
        if (m_rready[r_grant_q]) r_state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        s_rready = 1'b1;
        if (s_rvalid) begin
          rptr_d    = r_grant_q;
          r_state_d = ST_IDLE;
        end
      end
`endif
      default: r_state_d = ST_IDLE;
    endcase
  end

  assign m_rdata = {NUM_MASTERS{r_data}};

  // State, grant, pointer and flag registers for both paths.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q <= ST_IDLE;
      r_state_q <= ST_IDLE;
      w_grant_q <= '0;
      r_grant_q <= '0;
      wptr_q    <= IDX_W'(NUM_MASTERS - 1);
      rptr_q    <= IDX_W'(NUM_MASTERS - 1);
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef AXI_ARB_TIMEOUT_EN
      w_cnt_q   <= '0;
      r_cnt_q   <= '0;
`endif
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      w_grant_q <= w_grant_d;
      r_grant_q <= r_grant_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef AXI_ARB_TIMEOUT_EN
      w_cnt_q   <= w_cnt_d;
      r_cnt_q   <= r_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed testbench for axi_lite_rr_arbiter (3 masters, 32-bit address,
// 64-bit data). Define AXI_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_axi_lite_rr_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 64;

  logic clk, rstn;
  logic [N*AW-1:0]   m_awaddr, m_araddr;
  logic [N*3-1:0]    m_awport, m_arport;
  logic [N-1:0]      m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [N-1:0]      m_arvalid, m_arready, m_rvalid, m_rready;
  logic [N*DW-1:0]   m_wdata, m_rdata;
  logic [N*DW/8-1:0] m_wstrb;
  logic [N*2-1:0]    m_bresp, m_rresp;
  logic [AW-1:0]     s_awaddr, s_araddr;
  logic [2:0]        s_awport, s_arport;
  logic              s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic              s_arvalid, s_arready, s_rvalid, s_rready;
  logic [DW-1:0]     s_wdata, s_rdata;
  logic [DW/8-1:0]   s_wstrb;
  logic [1:0]        s_bresp, s_rresp;

  int n_pass  = 0;
  int n_total = 0;

  axi_lite_rr_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rstn(rstn),
    .m_awaddr(m_awaddr), .m_awport(m_awport), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arport(m_arport), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rresp(m_rresp), .m_rdata(m_rdata), .m_rready(m_rready),
    .s_awaddr(s_awaddr), .s_awport(s_awport), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arport(s_arport), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rresp(s_rresp), .s_rdata(s_rdata), .s_rready(s_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed per-master request attributes.
  function automatic logic [AW-1:0] awaddr_of(input int i);
    return 32'hA000_0000 + 32'(i) * 32'h100;
  endfunction
  function automatic logic [AW-1:0] araddr_of(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction
  function automatic logic [DW-1:0] wdata_of(input int i);
    return 64'hDA7A_0000_0000_0000 + 64'(i);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  req;
    int          exp_g;
    logic [63:0] data;
    logic [1:0]  resp;
  } rd_vec_t;

  rd_vec_t vecs[13];

  // One complete read transaction: request mask in, expected grant checked.
  task automatic rd_txn(input int idx, input rd_vec_t v);
    logic [2:0] oh;
    oh = 3'(1 << v.exp_g);
    m_arvalid = v.req;
    tick();
    check($sformatf("rd%0d_arvalid", idx), s_arvalid, 1'b1);
    check($sformatf("rd%0d_araddr", idx), s_araddr, araddr_of(v.exp_g));
    check($sformatf("rd%0d_arport", idx), s_arport, 3'(v.exp_g + 1));
    s_arready = 1'b1;
    #1;
    check($sformatf("rd%0d_arready", idx), m_arready, oh);
    tick();
    m_arvalid = '0;
    s_arready = 1'b0;
    m_rready  = 3'b111;
    s_rvalid  = 1'b1;
    s_rdata   = v.data;
    s_rresp   = v.resp;
    #1;
    check($sformatf("rd%0d_rvalid", idx), m_rvalid, oh);
    check($sformatf("rd%0d_rresp", idx), m_rresp, 6'(v.resp) << (2 * v.exp_g));
    check($sformatf("rd%0d_rdata", idx), m_rdata, {3{v.data}});
    tick();
    s_rvalid = 1'b0;
    check($sformatf("rd%0d_rvalid_done", idx), m_rvalid, 3'b000);
    $display("read txn %0d: req=%b grant=%0d", idx, v.req, v.exp_g);
  endtask

  initial begin
    // Hand-computed round-robin order; pointer starts at master 2.
    vecs[0]  = '{3'b111, 0, 64'h0123_4567_89AB_CDEF, 2'b00};
    vecs[1]  = '{3'b111, 1, 64'h1111_2222_3333_4444, 2'b01};
    vecs[2]  = '{3'b111, 2, 64'hDEAD_BEEF_0000_0002, 2'b00};
    vecs[3]  = '{3'b111, 0, 64'hCAFE_0000_0000_0003, 2'b10};
    vecs[4]  = '{3'b111, 1, 64'h0000_0000_0000_0004, 2'b00};
    vecs[5]  = '{3'b111, 2, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11};
    vecs[6]  = '{3'b101, 0, 64'h5555_AAAA_5555_AAAA, 2'b00};
    vecs[7]  = '{3'b101, 2, 64'hAAAA_5555_AAAA_5555, 2'b01};
    vecs[8]  = '{3'b010, 1, 64'h0000_1111_0000_1111, 2'b00};
    vecs[9]  = '{3'b110, 2, 64'h8000_0000_0000_0001, 2'b00};
    vecs[10] = '{3'b001, 0, 64'h7777_0000_7777_0000, 2'b10};
    vecs[11] = '{3'b100, 2, 64'h0F0F_0F0F_0F0F_0F0F, 2'b00};
    vecs[12] = '{3'b011, 0, 64'h1234_0000_0000_5678, 2'b01};

    for (int i = 0; i < N; i++) begin
      m_awaddr[i*AW +: AW] = awaddr_of(i);
      m_araddr[i*AW +: AW] = araddr_of(i);
      m_awport[i*3 +: 3]   = 3'(i + 1);
      m_arport[i*3 +: 3]   = 3'(i + 1);
      m_wdata[i*DW +: DW]  = wdata_of(i);
    end
    m_wstrb = {8'hFF, 8'h0F, 8'hF0};

    // Reset with busy inputs: every output must still be zero.
    rstn = 1'b0;
    m_awvalid = 3'b011; m_wvalid = 3'b011; m_arvalid = 3'b111;
    m_bready = 3'b111; m_rready = 3'b111;
    s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
    s_bvalid = 1'b1; s_bresp = 2'b11; s_rvalid = 1'b1; s_rresp = 2'b11;
    s_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_awvalid", s_awvalid, 1'b0);
    check("rst_s_wvalid", s_wvalid, 1'b0);
    check("rst_s_arvalid", s_arvalid, 1'b0);
    check("rst_s_ready", {s_bready, s_rready}, 2'b00);
    check("rst_m_ready", {m_awready, m_wready, m_arready}, 9'd0);
    check("rst_m_valid", {m_bvalid, m_rvalid}, 6'd0);
    check("rst_m_resp", {m_bresp, m_rresp}, 12'd0);
    check("rst_m_rdata", m_rdata, '0);
    check("rst_s_addr", {s_awaddr, s_araddr, s_wstrb, s_wdata}, '0);
    $display("reset state checked");
    m_awvalid = '0; m_wvalid = '0; m_arvalid = '0; m_bready = '0; m_rready = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0;
    s_bvalid = 1'b0; s_bresp = 2'b00; s_rvalid = 1'b0; s_rresp = 2'b00; s_rdata = '0;
    @(negedge clk);
    rstn = 1'b1;

    // Write: masters 0 and 1 request; W accepted 3 cycles before AW.
    m_awvalid = 3'b011; m_wvalid = 3'b011;
    tick();
    check("wr0_awvalid", s_awvalid, 1'b1);
    check("wr0_awaddr", s_awaddr, awaddr_of(0));
    check("wr0_awport", s_awport, 3'd1);
    check("wr0_wvalid", s_wvalid, 1'b1);
    check("wr0_wstrb", s_wstrb, 8'hF0);
    check("wr0_wdata", s_wdata, wdata_of(0));
    s_wready = 1'b1;
    #1;
    check("wr0_wready", m_wready, 3'b001);
    check("wr0_awready_wait", m_awready, 3'b000);
    tick();
    check("wr0_wvalid_done", s_wvalid, 1'b0);
    check("wr0_wready_done", m_wready, 3'b000);
    check("wr0_awvalid_held", s_awvalid, 1'b1);
    tick();
    tick();
    s_awready = 1'b1;
    #1;
    check("wr0_awready", m_awready, 3'b001);
    tick();
    s_awready = 1'b0; s_wready = 1'b0;
    m_awvalid = 3'b010; m_wvalid = 3'b010;
    s_bvalid = 1'b1; s_bresp = 2'b00; m_bready = 3'b111;
    #1;
    check("wr0_bvalid", m_bvalid, 3'b001);
    check("wr0_bresp", m_bresp, 6'd0);
    check("wr0_bready", s_bready, 1'b1);
    check("wr0_resp_awvalid", s_awvalid, 1'b0);
    tick();
    s_bvalid = 1'b0;
    check("wr0_bvalid_done", m_bvalid, 3'b000);
    check("wr0_no_same_cycle_grant", s_awvalid, 1'b0);
    $display("write txn 0: grant=0 wstrb=f0 bresp=0");
    tick();
    check("wr1_awaddr", s_awaddr, awaddr_of(1));
    check("wr1_wstrb", s_wstrb, 8'h0F);
    s_awready = 1'b1; s_wready = 1'b1;
    #1;
    check("wr1_readies", {m_awready, m_wready}, 6'b010_010);
    tick();
    s_awready = 1'b0; s_wready = 1'b0;
    m_awvalid = '0; m_wvalid = '0;
    s_bvalid = 1'b1; s_bresp = 2'b10; m_bready = 3'b000;
    #1;
    check("wr1_bvalid", m_bvalid, 3'b010);
    check("wr1_bresp", m_bresp, 6'b00_10_00);
    check("wr1_bready_low", s_bready, 1'b0);
    tick();
    check("wr1_bvalid_hold", m_bvalid, 3'b010);
    m_bready = 3'b010;
    #1;
    check("wr1_bready", s_bready, 1'b1);
    tick();
    s_bvalid = 1'b0;
    check("wr1_bvalid_done", m_bvalid, 3'b000);
    $display("write txn 1: grant=1 bresp=2");

    // Read round-robin table.
    for (int i = 0; i < 13; i++) rd_txn(i, vecs[i]);

    // Overlapping write (master 1) and read (master 0).
    m_awvalid = 3'b010; m_wvalid = 3'b010; m_arvalid = 3'b001;
    tick();
    check("ov_awaddr", s_awaddr, awaddr_of(1));
    check("ov_araddr", s_araddr, araddr_of(0));
    s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
    #1;
    check("ov_readies", {m_awready, m_arready}, 6'b010_001);
    tick();
    s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0;
    m_awvalid = '0; m_wvalid = '0; m_arvalid = '0;
    s_bvalid = 1'b1; s_bresp = 2'b01; s_rvalid = 1'b1; s_rresp = 2'b00;
    s_rdata = 64'hBEEF_0000_1234_5678; m_bready = 3'b111; m_rready = 3'b111;
    #1;
    check("ov_bvalid", m_bvalid, 3'b010);
    check("ov_rvalid", m_rvalid, 3'b001);
    check("ov_bresp", m_bresp, 6'b00_01_00);
    check("ov_rdata", m_rdata, {3{64'hBEEF_0000_1234_5678}});
    tick();
    s_bvalid = 1'b0; s_rvalid = 1'b0;
    check("ov_done", {m_bvalid, m_rvalid}, 6'd0);
    $display("overlap txn: write grant=1 read grant=0");

    // Reset in the middle of a write response.
    m_awvalid = 3'b100; m_wvalid = 3'b100;
    tick();
    check("rr_awaddr", s_awaddr, awaddr_of(2));
    s_awready = 1'b1; s_wready = 1'b1;
    tick();
    s_awready = 1'b0; s_wready = 1'b0;
    m_awvalid = '0; m_wvalid = '0;
    s_bvalid = 1'b1; s_bresp = 2'b01; m_bready = 3'b000;
    #1;
    check("rr_bvalid_pre", m_bvalid, 3'b100);
    #1;
    rstn = 1'b0;
    #1;
    check("rr_bvalid_rst", m_bvalid, 3'b000);
    check("rr_bresp_rst", m_bresp, 6'd0);
    check("rr_bready_rst", s_bready, 1'b0);
    s_bvalid = 1'b0; s_bresp = 2'b00;
    @(negedge clk);
    rstn = 1'b1;
    m_awvalid = 3'b111; m_wvalid = 3'b111;
    tick();
    check("rr_post_grant", s_awaddr, awaddr_of(0));
    s_awready = 1'b1; s_wready = 1'b1;
    tick();
    s_awready = 1'b0; s_wready = 1'b0;
    m_awvalid = '0; m_wvalid = '0;
    s_bvalid = 1'b1; m_bready = 3'b001;
    #1;
    check("rr_post_bvalid", m_bvalid, 3'b001);
    tick();
    s_bvalid = 1'b0; m_bready = '0;
    $display("reset-in-resp txn: post-reset grant=0");

`ifdef AXI_ARB_TIMEOUT_EN
    // Watchdog: slave withholds rvalid after reset; master 1 reads.
    begin
      int k;
      m_arvalid = 3'b010;
      tick();
      s_arready = 1'b1;
      tick();
      s_arready = 1'b0; m_arvalid = '0; m_rready = '0; s_rvalid = 1'b0;
      k = 0;
      while (m_rvalid == 3'b000 && k < 100) begin
        tick();
        k++;
      end
      check("to_cycles", 32'(k), 32'd16);
      check("to_rvalid", m_rvalid, 3'b010);
      check("to_rresp", m_rresp, 6'b00_11_00);
      check("to_rdata", m_rdata, '0);
      check("to_rready_low", s_rready, 1'b0);
      m_rready = 3'b010;
      tick();
      m_rready = '0;
      check("to_drain_rvalid", m_rvalid, 3'b000);
      check("to_drain_rready", s_rready, 1'b1);
      s_rvalid = 1'b1; s_rdata = 64'h0BAD_0BAD_0BAD_0BAD; s_rresp = 2'b00;
      #1;
      check("to_drain_hidden", {m_rvalid, m_rdata}, '0);
      tick();
      s_rvalid = 1'b0;
      check("to_drain_done", s_rready, 1'b0);
      m_arvalid = 3'b111;
      tick();
      check("to_next_grant", s_araddr, araddr_of(2));
      m_arvalid = '0;
      $display("timeout txn: decerr after %0d cycles", k);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_lite_rr_arbiter.md
Name: axi_lite_rr_arbiter

Overview:
- Parametrised N-master to 1-slave arbiter for the AXI-lite style bus used across the SoC. Channels: aw/w/b write, ar/r read, 3-bit port attribute on aw and ar.
- Sits between the core-side masters (IF, MEM, PTW, DMA) and a single memory or MMIO slave.
- Read and write paths arbitrate independently with round-robin fairness. Each path has one outstanding transaction.

Parameters:
- NUM_MASTERS, 2, number of master ports (2..8).
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 64, data width; strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, response watchdog limit. Used only with AXI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- m_awaddr/m_araddr  in  NUM_MASTERS*ADDR_WIDTH  per-master addresses, master i at slice i
- m_awport/m_arport  in  NUM_MASTERS*3  per-master port attribute
- m_awvalid/m_wvalid/m_arvalid  in  NUM_MASTERS  request valids
- m_wdata  in  NUM_MASTERS*DATA_WIDTH  write data
- m_wstrb  in  NUM_MASTERS*DATA_WIDTH/8  write strobes
- m_bready/m_rready  in  NUM_MASTERS  response readies
- m_awready/m_wready/m_arready  out  NUM_MASTERS  request readies
- m_bvalid/m_rvalid  out  NUM_MASTERS  response valids
- m_bresp/m_rresp  out  NUM_MASTERS*2  responses
- m_rdata  out  NUM_MASTERS*DATA_WIDTH  read data, broadcast to all masters
- s_awaddr, s_awport, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready  out  matching widths  slave write request
- s_awready, s_wready, s_bvalid, s_bresp  in  matching widths  slave write response
- s_araddr, s_arport, s_arvalid, s_rready  out  matching widths  slave read request
- s_arready, s_rvalid, s_rresp, s_rdata  in  matching widths  slave read response

Behaviour:
- Reset (rstn=0, asynchronous):
  - Both FSMs go to IDLE.
  - Grant registers are 0.
  - Round-robin pointers are NUM_MASTERS-1, so master 0 wins first.
  - Every valid/ready output is 0. Data, addr, port, resp and strobe outputs are 0.
- Write FSM states are IDLE, ADDR, RESP.
  - IDLE: if any m_awvalid is set, pick the first requester scanning from wptr+1 modulo N. Register the grant and go to ADDR. Request latency is 1 cycle.
  - ADDR: s_aw* and s_w* are combinationally muxed from the granted master. s_awvalid = m_awvalid[g] & ~aw_done; s_wvalid = m_wvalid[g] & ~w_done. m_awready[g] = s_awready & ~aw_done; m_wready[g] likewise. Once both aw_done and w_done are set, go to RESP.
  - aw_done and w_done are separate flags. AW and W may complete in either order or in the same cycle.
  - RESP: s_bready = m_bready[g]; m_bvalid[g] = s_bvalid; m_bresp[g] = s_bresp. On the handshake, set wptr=g, clear the flags, and go to IDLE.
  - A new grant cannot be issued in the same cycle as the response handshake.
- Read FSM states are IDLE, ADDR, RESP, with the same rules on the ar and r channels and rptr. m_rdata is broadcast; only m_rvalid[g] is set.
- Non-granted masters always see ready=0 and valid=0.
- A grant is held until its response handshake completes. Master valids that drop mid-ADDR are forwarded as-is; the protocol violation is the master's responsibility.
- Read and write paths may serve the same master concurrently.
- Reset asserted mid-transaction aborts it. No response is generated.

Optional Feature:
- Macro: AXI_ARB_TIMEOUT_EN.
- When defined:
  - A per-path counter runs in RESP and clears on entry.
  - When the counter reaches TIMEOUT_CYCLES, the FSM drives m_bvalid[g] or m_rvalid[g] with resp=2'b11 (DECERR) and rdata=0 until the master handshakes.
  - It then enters a DRAIN state, holding s_bready/s_rready=1 until one slave response is absorbed, and then returns to IDLE.
  - If the slave responds in the same cycle the limit is reached, the real response wins.
- When undefined: no counter, no DRAIN state; RESP waits indefinitely.

Test Plan:
- Masters 0 and 1 both assert awvalid after reset -> master 0 granted, s_awaddr = m0 addr one cycle later; after b handshake, master 1 granted next.
- Three masters continuously request reads (N=3) -> grant order 0,1,2,0,1,2; no master is starved for more than 2 transactions.
- Slave raises s_wready 3 cycles before s_awready -> w_done latched, s_wvalid drops, single write with correct wstrb 8'hF0, then bresp=2'b00 to the correct master.
- Write from master 1 and read from master 0 overlap -> both complete independently; m_rvalid[1] and m_bvalid[0] never assert.
- rstn pulsed low while in RESP -> all outputs 0 in the same cycle; first post-reset grant goes to master 0.
- With AXI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave withholds rvalid -> master receives rresp=2'b11 after 16 cycles; a later slave rvalid is drained and not forwarded.
